// File: rtl/hc74_pkg.sv
// hc74_pkg: constants shared by the synchronous 74xx CLK-variant models
package hc74_pkg;
  localparam logic [7:0] HC_RESET_BYTE = 8'h00;
  localparam logic       HC_CK_IDLE    = 1'b1;
endpackage

// File: rtl/hc165_clk_if.sv
// hc165_clk_if: 74HC165 pin bundle; master drives PL_n/CP/CE_n/DS/D0..D7, slave drives Q7/Q7_n
interface hc165_clk_if;
  logic p1, p2, p15, p10;
  logic p11, p12, p13, p14, p3, p4, p5, p6;
  logic p9, p7;
  modport master (output p1, p2, p15, p10, p11, p12, p13, p14, p3, p4, p5, p6, input p9, p7);
  modport slave (input p1, p2, p15, p10, p11, p12, p13, p14, p3, p4, p5, p6, output p9, p7);
endinterface

// File: rtl/hc_pin_edge.sv
// hc_pin_edge: optional 2-flop synchronizer (HC165_SYNC_INPUTS_EN) plus rising-edge detect; ports clk, rst, d, q_sync, rise
module hc_pin_edge
  import hc74_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_sync,
  output logic rise
);
  logic prev;
`ifdef HC165_SYNC_INPUTS_EN
  logic s1, s2;
  always_ff @(posedge clk) begin
    s1 <= rst ? HC_CK_IDLE : d;
    s2 <= rst ? HC_CK_IDLE : s1;
  end
  assign q_sync = s2;
`else
  assign q_sync = d;
`endif
  always_ff @(posedge clk) prev <= rst ? HC_CK_IDLE : q_sync;
  assign rise = ~prev & q_sync;
endmodule

// File: rtl/hc165_clk.sv
// hc165_clk: clk-synchronous 74HC165 PISO; ports clk, rst, pins (hc165_clk_if.slave); macro HC165_SYNC_INPUTS_EN syncs all pins
module hc165_clk
  import hc74_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  hc165_clk_if.slave      pins
);
  localparam logic [9:0] PIN_IDLE = 10'b10_0000_0000;
  logic [9:0] raw;
  logic       pl_n, ds, rise, ck_sync_unused;
  logic [7:0] d, q;
  assign raw = {pins.p1, pins.p10, pins.p6, pins.p5, pins.p4, pins.p3,
                pins.p14, pins.p13, pins.p12, pins.p11};
`ifdef HC165_SYNC_INPUTS_EN
  logic [9:0] s1, s2;
  always_ff @(posedge clk) begin
    s1 <= rst ? PIN_IDLE : raw;
    s2 <= rst ? PIN_IDLE : s1;
  end
  assign {pl_n, ds, d} = s2;
`else
  assign {pl_n, ds, d} = raw;
`endif
  // CE_n ORed with CP forms the effective clock, so either pin can make the edge
  hc_pin_edge u_ck (
    .clk    (clk),
    .rst    (rst),
    .d      (pins.p2 | pins.p15),
    .q_sync (ck_sync_unused),
    .rise   (rise)
  );
  always_ff @(posedge clk)
    if (rst) q <= HC_RESET_BYTE;
    else if (!pl_n) q <= d;
    else if (rise) q <= {q[6:0], ds};
  assign pins.p9 = q[7];
  assign pins.p7 = ~q[7];
endmodule

// File: tb/tb_hc165_clk.sv
// tb_hc165_clk: table, directed and random checks of hc165_clk against a behavioural model
module tb_hc165_clk;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  localparam int HOLD = 3;
`ifdef HC165_SYNC_INPUTS_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  hc165_clk_if bus ();
  hc165_clk dut (.clk(clk), .rst(rst), .pins(bus));
  always #5 clk = ~clk;
  typedef struct { logic pl_n; logic ck; logic ds; logic [7:0] d; } pin_t;
  localparam pin_t IDLE = '{1'b1, 1'b1, 1'b0, 8'h00};
  pin_t h0 = IDLE, h1 = IDLE;
  logic [7:0] mq = 8'h00;
  logic mprev = 1'b1;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic r, pl, cp, ce, ds, input logic [7:0] d);
    pin_t cur, e;
    rst = r; bus.p1 = pl; bus.p2 = cp; bus.p15 = ce; bus.p10 = ds;
    {bus.p6, bus.p5, bus.p4, bus.p3, bus.p14, bus.p13, bus.p12, bus.p11} = d;
    @(posedge clk);
    cur = '{pl, cp | ce, ds, d};
    if (r) begin
      mq = 8'h00; mprev = 1'b1; h0 = IDLE; h1 = IDLE;
    end else begin
      e = SYNC ? h1 : cur;
      h1 = h0; h0 = cur;
      if (!e.pl_n) mq = e.d;
      else if (!mprev && e.ck) mq = {mq[6:0], e.ds};
      mprev = e.ck;
    end
    @(negedge clk);
    chk("model_p9", {7'd0, bus.p9}, {7'd0, mq[7]});
    chk("model_p7", {7'd0, bus.p7}, {7'd0, ~mq[7]});
  endtask
  task automatic hold(input logic r, pl, cp, ce, ds, input logic [7:0] d);
    for (int k = 0; k < HOLD; k++) cyc(r, pl, cp, ce, ds, d);
  endtask
  typedef struct { logic r; logic pl; logic cp; logic ce; logic ds; logic [7:0] d; logic [7:0] q; } vec_t;
  vec_t tbl[18];
  initial begin
    logic [7:0] a;
    logic [7:0] save;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h3C};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h79};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h79};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h79};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h79};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h79};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF2};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hF2};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hF2};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01};
    for (int i = 0; i < 18; i++) begin
      hold(tbl[i].r, tbl[i].pl, tbl[i].cp, tbl[i].ce, tbl[i].ds, tbl[i].d);
      chk($sformatf("tbl%0d_q", i), dut.q, tbl[i].q);
      chk($sformatf("tbl%0d_p9", i), {7'd0, bus.p9}, {7'd0, tbl[i].q[7]});
      chk($sformatf("tbl%0d_p7", i), {7'd0, bus.p7}, {7'd0, ~tbl[i].q[7]});
    end
    a = 8'hA5;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    hold(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("a5_load_p9", {7'd0, bus.p9}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      hold(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      chk($sformatf("a5_shift%0d_p9", i), {7'd0, bus.p9}, {7'd0, (i < 7) ? a[6-i] : 1'b0});
      hold(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      hold(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      hold(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    end
    chk("fill_q", dut.q, 8'hFF);
    save = mq;
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      hold(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    end
    chk("inhibit_q", dut.q, save);
    hold(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ce_fall_q", dut.q, 8'hFF);
    hold(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("ce_rise_q", dut.q, 8'hFE);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("mid_reset_p9", {7'd0, bus.p9}, 8'h00);
    chk("mid_reset_q", dut.q, 8'h00);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
          $urandom_range(0, 5) == 0, 1'($urandom), 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
